// File: rtl/cbus_rr_arbiter.sv
// N-port round-robin arbiter merging cbus masters onto one cbus slave.
// Ownership is held for a whole burst; each grant costs one idle arbitration cycle.
module cbus_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 4,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          ireq_valid,
  input  logic [NUM_PORTS-1:0]          ireq_is_write,
  input  logic [NUM_PORTS*3-1:0]        ireq_size,
  input  logic [NUM_PORTS*ADDR_W-1:0]   ireq_addr,
  input  logic [NUM_PORTS*STRB_W-1:0]   ireq_strobe,
  input  logic [NUM_PORTS*DATA_W-1:0]   ireq_data,
  input  logic [NUM_PORTS*LEN_W-1:0]    ireq_len,
  output logic [NUM_PORTS-1:0]          iresp_ready,
  output logic [NUM_PORTS-1:0]          iresp_last,
  output logic [NUM_PORTS*DATA_W-1:0]   iresp_data,
  output logic                          oreq_valid,
  output logic                          oreq_is_write,
  output logic [2:0]                    oreq_size,
  output logic [ADDR_W-1:0]             oreq_addr,
  output logic [STRB_W-1:0]             oreq_strobe,
  output logic [DATA_W-1:0]             oreq_data,
  output logic [LEN_W-1:0]              oreq_len,
  input  logic                          oresp_ready,
  input  logic                          oresp_last,
  input  logic [DATA_W-1:0]             oresp_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            r_state;
  logic [ID_W-1:0]   r_owner;
  logic [ID_W-1:0]   r_ptr;

  logic [2*NUM_PORTS-1:0] w_rot;
  logic                   w_found;
  logic [ID_W-1:0]        w_pick;
  logic [ID_W-1:0]        w_next_ptr;
  logic                   w_busy;
  logic                   w_valid;
  logic                   w_is_write;
  logic [2:0]             w_size;
  logic [ADDR_W-1:0]      w_addr;
  logic [STRB_W-1:0]      w_strobe;
  logic [DATA_W-1:0]      w_data;
  logic [LEN_W-1:0]       w_len;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set bit wins.
  assign w_rot = {ireq_valid, ireq_valid} >> r_ptr;

  always_comb begin
    int unsigned sum;
    w_found = 1'b0;
    w_pick  = '0;
    sum     = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        sum     = 32'(r_ptr) + i;
        if (sum >= NUM_PORTS) begin
          sum = sum - NUM_PORTS;
        end
        w_pick = ID_W'(sum);
      end
    end
  end

  assign w_next_ptr = (r_owner == ID_W'(NUM_PORTS - 1)) ? '0 : r_owner + ID_W'(1);
  assign w_busy     = (r_state == StBusy);

  always_comb begin
    w_valid    = 1'b0;
    w_is_write = 1'b0;
    w_size     = '0;
    w_addr     = '0;
    w_strobe   = '0;
    w_data     = '0;
    w_len      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (r_owner == ID_W'(i)) begin
        w_valid    = ireq_valid[i];
        w_is_write = ireq_is_write[i];
        w_size     = ireq_size[i*3 +: 3];
        w_addr     = ireq_addr[i*ADDR_W +: ADDR_W];
        w_strobe   = ireq_strobe[i*STRB_W +: STRB_W];
        w_data     = ireq_data[i*DATA_W +: DATA_W];
        w_len      = ireq_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (oresp_ready && oresp_last) begin
            r_state <= StIdle;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oreq_valid    = w_busy & w_valid;
  assign oreq_is_write = w_is_write;
  assign oreq_size     = w_size;
  assign oreq_addr     = w_addr;
  assign oreq_strobe   = w_strobe;
  assign oreq_data     = w_data;
  assign oreq_len      = w_len;

  always_comb begin
    iresp_ready = '0;
    iresp_last  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_busy && (r_owner == ID_W'(i))) begin
        iresp_ready[i] = oresp_ready;
        iresp_last[i]  = oresp_last;
      end
    end
  end

  assign iresp_data = {NUM_PORTS{oresp_data}};
  assign grant_id   = r_owner;
  assign busy       = w_busy;

endmodule
